// File: rtl/core_pkg.sv
// Shared core-wide definitions: register-file geometry and the address/data
// types used by decode, the writeback-select mux and the register file.
package core_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 16;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: x0 gating, optional write-through
// bypass from the writeback stage, and selection from the storage array.
module rf_read_port
  import core_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic      rst,
  input  reg_addr_t addr,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  xlen_t     wr_data,
  input  xlen_t     mem [NREGS],
  output xlen_t     data
);

  // Priority: reset and x0 force zero, then the in-flight write, then storage.
  always_comb begin
    data = mem[addr];
    if (rst || (addr == REG_ZERO)) begin
      data = '0;
    end else if (BYPASS && wr_en && (wr_addr == addr)) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32-entry integer register file fed by the writeback-select mux. Two bypassed
// read ports for decode/execute, one unbypassed debug port, and a saturating
// count of committed non-x0 writes.
module reg_file_wb
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [AW-1:0]     rd_addr1,
  output logic [XLEN-1:0]   rd_data1,
  input  logic [AW-1:0]     rd_addr2,
  output logic [XLEN-1:0]   rd_data2,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  output logic [CNT_W-1:0]  wr_count
);

  xlen_t             mem [NREGS];
  logic [CNT_W-1:0]  count;
  logic              commit;

  // A write commits only outside reset and never to x0.
  assign commit = wr_en && (wr_addr != REG_ZERO);

  // Storage and write counter; reset clears every entry so reads are never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
      count <= '0;
    end else if (commit) begin
      mem[wr_addr] <= wr_data;
      if (count != {CNT_W{1'b1}}) begin
        count <= count + 1'b1;
      end
    end
  end

  assign wr_count = count;

  rf_read_port #(.BYPASS(1'b1)) u_rs1 (
    .rst     (rst),
    .addr    (rd_addr1),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .mem     (mem),
    .data    (rd_data1)
  );

  rf_read_port #(.BYPASS(1'b1)) u_rs2 (
    .rst     (rst),
    .addr    (rd_addr2),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .mem     (mem),
    .data    (rd_data2)
  );

  // Debug port shows stored state only, so a same-cycle write appears next cycle.
  rf_read_port #(.BYPASS(1'b0)) u_dbg (
    .rst     (rst),
    .addr    (dbg_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .mem     (mem),
    .data    (dbg_data)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: the driver pushes expected values for the
// cycle it sets up, and a negedge monitor pops and compares them.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] ref_mem [32];
  logic [15:0] ref_cnt;

  localparam int S_RD1 = 0;
  localparam int S_RD2 = 1;
  localparam int S_DBG = 2;
  localparam int S_CNT = 3;

  always #5 clk = ~clk;

  reg_file_wb dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1),
    .rd_addr2 (rd_addr2),
    .rd_data2 (rd_data2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  // Monitor: compare every expectation queued for this cycle at the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.sel)
        S_RD1:   act = rd_data1;
        S_RD2:   act = rd_data2;
        S_DBG:   act = dbg_data;
        default: act = {16'h0, wr_count};
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic push(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] ad);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr1 = a1; rd_addr2 = a2; dbg_addr = ad;
  endtask

  // Advance one clock and apply the same edge to the reference model.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      ref_cnt = '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      ref_mem[wr_addr] = wr_data;
      if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
    end
    #1;
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a, input logic byp);
    if (rst || a == 5'd0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return ref_mem[a];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    ref_cnt = '0;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10, 5'd11);
    @(posedge clk); #1;

    // Outputs forced to zero while reset is asserted.
    push("rst_rd1", S_RD1, 32'h0);
    push("rst_rd2", S_RD2, 32'h0);
    push("rst_dbg", S_DBG, 32'h0);
    step();

    // Every address reads zero after reset.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 5'(a));
      push($sformatf("clr_rd1_x%0d", a), S_RD1, 32'h0);
      push($sformatf("clr_rd2_x%0d", 31 - a), S_RD2, 32'h0);
      push($sformatf("clr_dbg_x%0d", a), S_DBG, 32'h0);
      push("clr_cnt", S_CNT, 32'h0);
      step();
    end

    // Basic write to x5, bypassed read in the same cycle.
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
    push("wr5_byp_rd1", S_RD1, 32'hDEADBEEF);
    push("wr5_rd2_x0", S_RD2, 32'h0);
    push("wr5_dbg_old", S_DBG, 32'h0);
    push("wr5_cnt", S_CNT, 32'h0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    push("rd5_rd1", S_RD1, 32'hDEADBEEF);
    push("rd5_rd2", S_RD2, 32'hDEADBEEF);
    push("rd5_dbg", S_DBG, 32'hDEADBEEF);
    push("rd5_cnt", S_CNT, 32'h1);
    step();

    // x0 is immutable and its writes are not counted.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    push("x0w_rd1", S_RD1, 32'h0);
    push("x0w_rd2", S_RD2, 32'h0);
    push("x0w_dbg", S_DBG, 32'h0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    push("x0n_rd1", S_RD1, 32'h0);
    push("x0n_dbg", S_DBG, 32'h0);
    push("x0n_cnt", S_CNT, 32'h1);
    step();

    // Bypass against an older stored value in x7.
    drive(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd5, 5'd0, 5'd0);
    push("wr7a_rd1_x5", S_RD1, 32'hDEADBEEF);
    step();
    drive(1'b0, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, 5'd7);
    push("byp7_rd1", S_RD1, 32'h22222222);
    push("byp7_rd2", S_RD2, 32'h22222222);
    push("byp7_dbg", S_DBG, 32'h11111111);
    push("byp7_cnt", S_CNT, 32'h2);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 5'd7);
    push("post7_dbg", S_DBG, 32'h22222222);
    push("post7_rd1", S_RD1, 32'h22222222);
    push("post7_rd2", S_RD2, 32'hDEADBEEF);
    push("post7_cnt", S_CNT, 32'h3);
    step();

    // Reset colliding with a write: write is dropped, outputs zero during reset.
    drive(1'b0, 1'b1, 5'd3, 32'h12345678, 5'd0, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd7, 5'd3);
    push("col_rd1", S_RD1, 32'h0);
    push("col_rd2", S_RD2, 32'h0);
    push("col_dbg", S_DBG, 32'h0);
    push("col_cnt_pre", S_CNT, 32'h4);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 5'd3);
    push("aft_rd1_x3", S_RD1, 32'h0);
    push("aft_rd2_x7", S_RD2, 32'h0);
    push("aft_dbg_x3", S_DBG, 32'h0);
    push("aft_cnt", S_CNT, 32'h0);
    step();

    // Random write/read regression against the reference array.
    for (int n = 0; n < 300; n++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      if (n % 4 == 0) rd_addr1 = wr_addr;
      push("rnd_rd1", S_RD1, m_rd(rd_addr1, 1'b1));
      push("rnd_rd2", S_RD2, m_rd(rd_addr2, 1'b1));
      push("rnd_dbg", S_DBG, m_rd(dbg_addr, 1'b0));
      push("rnd_cnt", S_CNT, {16'h0, ref_cnt});
      step();
    end

    // Saturation: more than 65535 committed writes.
    for (int n = 0; n < 65540; n++) begin
      drive(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd0, 5'd9);
    push("sat_cnt", S_CNT, 32'h0000FFFF);
    push("sat_byp", S_RD1, 32'hCAFEF00D);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
    push("sat_cnt_hold", S_CNT, 32'h0000FFFF);
    push("sat_dbg", S_DBG, 32'hCAFEF00D);
    push("sat_rd2", S_RD2, 32'hCAFEF00D);
    step();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32-entry integer register file for the RISC-V core.
- Sits directly downstream of the writeback-select 2:1 mux, which picks ALU result vs load data. That mux output drives wr_data here.
- Provides two combinational read ports to decode/execute, plus one debug read port.
- Implements write-through bypass so the pipelined core can read a value in the same cycle it is written back.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers
- AW, 5, register address width; must satisfy 2**AW == NREGS

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write enable from writeback stage
- wr_addr  input  AW  destination register (rd)
- wr_data  input  XLEN  writeback value (output of writeback-select mux)
- rd_addr1  input  AW  source register rs1
- rd_data1  output  XLEN  value of rs1
- rd_addr2  input  AW  source register rs2
- rd_data2  output  XLEN  value of rs2
- dbg_addr  input  AW  debug/test read address
- dbg_data  output  XLEN  debug read value; no bypass
- wr_count  output  16  number of committed non-x0 writes since reset; saturating

Behaviour:
- Reset:
  - Synchronous and active-high. On a rising clk edge with rst=1, all NREGS entries clear to 0 and wr_count clears to 0.
  - While rst=1, rd_data1, rd_data2 and dbg_data are forced to 0.
  - rst has priority over wr_en in the same cycle: the write is dropped.
- Write:
  - On a rising edge with rst=0, wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data.
  - Write latency is one cycle to storage.
  - Writes to x0 are discarded and do not increment wr_count.
- Read (combinational, zero latency):
  - rd_dataN = 0 if rd_addrN==0.
  - Otherwise rd_dataN = wr_data if (wr_en && wr_addr==rd_addrN), i.e. write-through bypass.
  - Otherwise rd_dataN = mem[rd_addrN].
  - Both read ports may address the same register; both return the same value.
- dbg_data:
  - Equals mem[dbg_addr] (0 for addr 0).
  - Reflects stored state only: a same-cycle write becomes visible to dbg_data on the next cycle.
- wr_count:
  - Increments by 1 on each committed non-x0 write.
  - Saturates at 16'hFFFF and does not wrap.
- x0 read value is always 0, regardless of storage contents.
- No X propagation: all entries are defined after the first reset edge.
- Reset mid-stream: a write presented in the same cycle as rst is lost. Bypass still presents wr_data combinationally only while rst=0.
- No state machine. State is the storage array plus the saturating counter.

Decomposition:
- Shared package core_pkg holds:
  - XLEN, NREGS, AW constants
  - REG_ZERO = 5'd0
  - reg_addr_t / xlen_t width definitions, reused by decode and the writeback mux.
- One natural sub-module: rf_read_port, the per-port combinational logic (x0 gating, bypass compare, array select).
  - Instantiated twice for rs1/rs2.
  - dbg port uses the same module with bypass disabled via a parameter BYPASS=0.

Test Plan:
- Reset then read all: rst=1 one cycle, then read every address via rd_addr1/rd_addr2/dbg_addr -> all return 0, wr_count=0.
- Basic write/read: write x5=32'hDEADBEEF, next cycle rd_addr1=5 -> rd_data1=32'hDEADBEEF; dbg_addr=5 -> same.
- x0 immutability: wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF -> rd_data1 (addr 0)=0 same and next cycle; wr_count unchanged.
- Bypass: x7 holds 32'h11111111; same cycle wr_en=1, wr_addr=7, wr_data=32'h22222222, rd_addr1=rd_addr2=7 -> both rd_data=32'h22222222, dbg_data=32'h11111111; next cycle dbg_data=32'h22222222.
- Reset vs write collision: rst=1 and wr_en=1, wr_addr=3, wr_data=32'hA5A5A5A5 in same cycle -> after the edge, x3=0, wr_count=0, outputs 0 during rst.
- Counter saturation: force 65540 consecutive non-x0 writes (or preload via a test hook) -> wr_count holds 16'hFFFF, no wrap; random write/read regression checked against a reference array model.
